// File: rtl/hmc_link_init_responder_if.sv
// ---------------------------------------------------------------------------
// hmc_link_init_responder_if
//
// Purpose: serial-link bundle between the openHMC controller (master) and the
// device-side link-init responder (slave).
//
// Signals:
//   P_RST_N               master->slave  HMC reset from the controller
//   LXTXPS                master->slave  controller TX power state
//   phy_bit_slip          master->slave  per-lane bit-slip pulses
//   phy_data_tx_link2phy  master->slave  controller TX word
//   phy_data_rx_phy2link  slave->master  word presented to the controller RX
//   FERR_N                slave->master  fatal error (active low)
//   LXRXPS                slave->master  device RX power state
//
// Transfer semantics: this is a free-running word-per-cycle link with no
// valid/ready flow control. Each side presents one word on every clk_hmc
// edge and the other side samples it unconditionally on that same edge;
// P_RST_N and LXTXPS act as level qualifiers, not per-word handshakes.
// ---------------------------------------------------------------------------
interface hmc_link_init_responder_if #(
  parameter int DWIDTH    = 256,
  parameter int NUM_LANES = 16
);
  logic                 P_RST_N;
  logic                 LXTXPS;
  logic [NUM_LANES-1:0] phy_bit_slip;
  logic [DWIDTH-1:0]    phy_data_tx_link2phy;
  logic [DWIDTH-1:0]    phy_data_rx_phy2link;
  logic                 FERR_N;
  logic                 LXRXPS;

  modport master (
    output P_RST_N,
    output LXTXPS,
    output phy_bit_slip,
    output phy_data_tx_link2phy,
    input  phy_data_rx_phy2link,
    input  FERR_N,
    input  LXRXPS
  );

  modport slave (
    input  P_RST_N,
    input  LXTXPS,
    input  phy_bit_slip,
    input  phy_data_tx_link2phy,
    output phy_data_rx_phy2link,
    output FERR_N,
    output LXRXPS
  );
endinterface

// File: rtl/hmc_link_init_responder.sv
// ---------------------------------------------------------------------------
// hmc_link_init_responder
//
// Purpose: device-side model of the HMC link-initialization handshake for the
// FPW=2, 16-lane, 256-bit openHMC configuration. Drives the controller RX
// with NULL -> TS1 training -> NULL -> one TRET flit -> NULL (ACTIVE),
// advancing on the controller's P_RST_N, LXTXPS and bit-slip activity.
//
// Ports:
//   clk_hmc     in   link clock
//   res_n_hmc   in   asynchronous active-low reset
//   link        slave modport of hmc_link_init_responder_if (see that file)
//   init_done   out  high while in ACTIVE
//   resp_state  out  encoded FSM state (debug): RESET=0 NULL_PRE=1 TS1=2
//                    NULL_POST=3 TRET=4 ACTIVE=5
//   ts1_seq     out  current TS1 sequence number
//
// Build option: define HMC_RESP_TS1_CHECK_EN to make TS1 exit additionally
// wait for 16 consecutive cycles of controller TS1 on lane 0 (upper 12 bits
// equal 12'hF03). Undefined: exit depends on slip quiet time and seq only.
//
// All outputs are registered; they are computed from the next state so a
// state change is visible one cycle after the triggering input is sampled.
// ---------------------------------------------------------------------------
module hmc_link_init_responder #(
  parameter int           DWIDTH         = 256,
  parameter int           NUM_LANES      = 16,
  parameter int           T_NULL_CYC     = 22,
  parameter int           SLIP_QUIET_CYC = 32,
  parameter int           NULL_CYC       = 16,
  parameter logic [127:0] TRET_FLIT      = 128'hA1098C6C380239830000000000000882
) (
  input  logic                     clk_hmc,
  input  logic                     res_n_hmc,
  hmc_link_init_responder_if.slave link,
  output logic                     init_done,
  output logic [2:0]               resp_state,
  output logic [3:0]               ts1_seq
);

  localparam logic [2:0] ST_RESET     = 3'd0;
  localparam logic [2:0] ST_NULL_PRE  = 3'd1;
  localparam logic [2:0] ST_TS1       = 3'd2;
  localparam logic [2:0] ST_NULL_POST = 3'd3;
  localparam logic [2:0] ST_TRET      = 3'd4;
  localparam logic [2:0] ST_ACTIVE    = 3'd5;

  // Phase counter holds the index of the current cycle within a NULL phase,
  // so the last cycle of a phase is at LEN-1.
  localparam logic [7:0] PRE_LAST  = 8'(T_NULL_CYC - 1);
  localparam logic [7:0] POST_LAST = 8'(NULL_CYC - 1);
  localparam logic [5:0] QUIET_TH  = 6'(SLIP_QUIET_CYC);

  logic [2:0]        state_q, state_d;
  logic [7:0]        phase_q, phase_d, phase_inc;
  logic [5:0]        quiet_q, quiet_d, quiet_inc;
  logic [3:0]        seq_q, seq_d;
  logic [DWIDTH-1:0] data_q, data_d;
  logic              ferr_q;
  logic              lxrxps_q;
  logic              init_done_q;

  logic              link_up;
  logic              slip_any;
  logic              ts1_ok;
  logic              unused_tx_bits;

  assign link_up   = link.P_RST_N & link.LXTXPS;
  assign slip_any  = |link.phy_bit_slip;
  assign phase_inc = (phase_q == 8'hFF) ? phase_q : phase_q + 8'd1;
  assign quiet_inc = (quiet_q == 6'h3F) ? quiet_q : quiet_q + 6'd1;

  // Only lane 0 of the controller TX word is ever inspected, and only when
  // the TS1 check is built in.
  assign unused_tx_bits = ^link.phy_data_tx_link2phy;

`ifdef HMC_RESP_TS1_CHECK_EN
  logic [4:0] det_q, det_d;
  logic       tx_match;

  assign tx_match = (link.phy_data_tx_link2phy[15:4] == 12'hF03);

  // Consecutive-match counter; any mismatch (or link drop) restarts it.
  always_comb begin
    det_d = det_q;
    if (!link_up || !tx_match) begin
      det_d = '0;
    end else if (det_q != 5'h1F) begin
      det_d = det_q + 5'd1;
    end
  end

  always_ff @(posedge clk_hmc or negedge res_n_hmc) begin
    if (!res_n_hmc) begin
      det_q <= '0;
    end else begin
      det_q <= det_d;
    end
  end

  // The current cycle counts toward the 16-cycle run.
  assign ts1_ok = (det_d >= 5'd16);
`else
  assign ts1_ok = 1'b1;
`endif

  // Next-state logic. quiet_inc already includes the current cycle, so a
  // slip in the cycle the threshold would be reached forces quiet_d to 0
  // and keeps the FSM in TS1.
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    quiet_d = quiet_q;
    seq_d   = seq_q;
    if (!link_up) begin
      state_d = ST_RESET;
      phase_d = '0;
      quiet_d = '0;
      seq_d   = '0;
    end else begin
      case (state_q)
        ST_RESET: begin
          state_d = ST_NULL_PRE;
          phase_d = '0;
        end
        ST_NULL_PRE: begin
          if (phase_q >= PRE_LAST) begin
            state_d = ST_TS1;
            phase_d = '0;
            quiet_d = '0;
            seq_d   = '0;
          end else begin
            phase_d = phase_inc;
          end
        end
        ST_TS1: begin
          seq_d   = seq_q + 4'd1;
          quiet_d = slip_any ? 6'd0 : quiet_inc;
          // Exit only on seq 15 so the last TS1 word is always seq 15.
          if (!slip_any && (quiet_inc >= QUIET_TH) && ts1_ok && (seq_q == 4'hF)) begin
            state_d = ST_NULL_POST;
            phase_d = '0;
            quiet_d = '0;
            seq_d   = '0;
          end
        end
        ST_NULL_POST: begin
          if (phase_q >= POST_LAST) begin
            state_d = ST_TRET;
            phase_d = '0;
          end else begin
            phase_d = phase_inc;
          end
        end
        ST_TRET: begin
          state_d = ST_ACTIVE;
        end
        ST_ACTIVE: begin
          state_d = ST_ACTIVE;
        end
        default: begin
          state_d = ST_RESET;
          phase_d = '0;
          quiet_d = '0;
          seq_d   = '0;
        end
      endcase
    end
  end

  // Output word for the state being entered. TS1 lanes: lane 0 = F030+seq,
  // last lane = F0C0+seq, all others = F050+seq.
  always_comb begin
    data_d = '0;
    case (state_d)
      ST_TS1: begin
        for (int l = 0; l < NUM_LANES; l++) begin
          if (l == 0) begin
            data_d[16*l +: 16] = 16'hF030 + {12'h000, seq_d};
          end else if (l == NUM_LANES - 1) begin
            data_d[16*l +: 16] = 16'hF0C0 + {12'h000, seq_d};
          end else begin
            data_d[16*l +: 16] = 16'hF050 + {12'h000, seq_d};
          end
        end
      end
      ST_TRET: begin
        data_d[127:0] = TRET_FLIT;
      end
      default: begin
        data_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk_hmc or negedge res_n_hmc) begin
    if (!res_n_hmc) begin
      state_q     <= ST_RESET;
      phase_q     <= '0;
      quiet_q     <= '0;
      seq_q       <= '0;
      data_q      <= '0;
      ferr_q      <= 1'b1;
      lxrxps_q    <= 1'b0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      quiet_q     <= quiet_d;
      seq_q       <= seq_d;
      data_q      <= data_d;
      ferr_q      <= 1'b1;
      lxrxps_q    <= (state_d != ST_RESET);
      init_done_q <= (state_d == ST_ACTIVE);
    end
  end

  assign link.phy_data_rx_phy2link = data_q;
  assign link.FERR_N               = ferr_q;
  assign link.LXRXPS               = lxrxps_q;
  assign init_done                 = init_done_q;
  assign resp_state                = state_q;
  assign ts1_seq                   = seq_q;

endmodule

// File: tb/tb_hmc_link_init_responder.sv
// ---------------------------------------------------------------------------
// tb_hmc_link_init_responder
//
// Directed bench for hmc_link_init_responder. The driver pushes one expected
// record per FSM transition (state, word, seq, flags, preceding word and the
// absolute cycle it must appear on) with hand-derived timing:
//   P_RST_N/LXTXPS raised right after edge B -> NULL_PRE at B+1,
//   first TS1 (seq 0) at B+23, TS1 lasts L cycles, NULL_POST at B+23+L,
//   TRET at B+39+L, ACTIVE at B+40+L.
// The monitor samples on the falling edge, pops a record on every state
// change and checks steady-state words cycle by cycle in between.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_hmc_link_init_responder;

  localparam int DW = 256;

  localparam logic [2:0] S_RESET     = 3'd0;
  localparam logic [2:0] S_NULL_PRE  = 3'd1;
  localparam logic [2:0] S_TS1       = 3'd2;
  localparam logic [2:0] S_NULL_POST = 3'd3;
  localparam logic [2:0] S_TRET      = 3'd4;
  localparam logic [2:0] S_ACTIVE    = 3'd5;

  localparam logic [DW-1:0] TRET_W = {128'h0, 128'hA1098C6C380239830000000000000882};

  typedef struct packed {
    logic [2:0]    state;
    logic [DW-1:0] data;
    logic [3:0]    seq;
    logic          init_done;
    logic          lxrxps;
    logic          chk_prev;
    logic [DW-1:0] prev;
    logic          chk_cyc;
    logic [31:0]   cyc;
  } exp_t;

  // ---------------- clock / reset ----------------
  logic        clk   = 1'b0;
  logic        res_n = 1'b0;
  logic [31:0] cyc   = '0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 32'd1;

  logic       init_done;
  logic [2:0] resp_state;
  logic [3:0] ts1_seq;

  hmc_link_init_responder_if #(.DWIDTH(DW), .NUM_LANES(16)) link ();

  hmc_link_init_responder dut (
    .clk_hmc    (clk),
    .res_n_hmc  (res_n),
    .link       (link),
    .init_done  (init_done),
    .resp_state (resp_state),
    .ts1_seq    (ts1_seq)
  );

  // ---------------- scoreboard ----------------
  exp_t exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;

  function automatic logic [DW-1:0] ts1_word(input logic [3:0] s);
    logic [DW-1:0] w;
    w = '0;
    for (int l = 0; l < 16; l++) begin
      if (l == 0)       w[16*l +: 16] = {12'hF03, s};
      else if (l == 15) w[16*l +: 16] = {12'hF0C, s};
      else              w[16*l +: 16] = {12'hF05, s};
    end
    return w;
  endfunction

  task automatic check(input string name, input logic [DW-1:0] got, input logic [DW-1:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [2:0] st, input logic [DW-1:0] d, input logic [3:0] sq,
                          input logic idn, input logic lx, input logic cp,
                          input logic [DW-1:0] pv, input logic cc, input logic [31:0] cy);
    exp_t e;
    e.state     = st;
    e.data      = d;
    e.seq       = sq;
    e.init_done = idn;
    e.lxrxps    = lx;
    e.chk_prev  = cp;
    e.prev      = pv;
    e.chk_cyc   = cc;
    e.cyc       = cy;
    exp_q.push_back(e);
  endtask

  task automatic push_pre_ts1(input logic [31:0] b);
    push_exp(S_NULL_PRE, '0,           4'd0, 1'b0, 1'b1, 1'b1, '0, 1'b1, b + 32'd1);
    push_exp(S_TS1,      ts1_word(4'd0), 4'd0, 1'b0, 1'b1, 1'b1, '0, 1'b1, b + 32'd23);
  endtask

  task automatic push_tail(input logic [31:0] b, input logic [31:0] ts1_len);
    push_exp(S_NULL_POST, '0,     4'd0, 1'b0, 1'b1, 1'b1, ts1_word(4'd15), 1'b1, b + 32'd23 + ts1_len);
    push_exp(S_TRET,      TRET_W, 4'd0, 1'b0, 1'b1, 1'b1, '0,              1'b1, b + 32'd39 + ts1_len);
    push_exp(S_ACTIVE,    '0,     4'd0, 1'b1, 1'b1, 1'b1, TRET_W,          1'b1, b + 32'd40 + ts1_len);
  endtask

  task automatic push_reset_next(input logic [31:0] at);
    push_exp(S_RESET, '0, 4'd0, 1'b0, 1'b0, 1'b1, '0, 1'b1, at);
  endtask

  task automatic drain(input int max_cyc);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < max_cyc) begin
      wait_cyc(1);
      n++;
    end
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending transitions required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  // ---------------- monitor ----------------
  logic [2:0]    last_state = '0;
  logic [3:0]    last_seq   = '0;
  logic [DW-1:0] last_data  = '0;
  logic [3:0]    next_seq;
  bit            started    = 1'b0;
  exp_t          me;

  always @(negedge clk) begin
    if (!started || resp_state != last_state) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_transition: got state %0d required state %0d (cycle %0d)",
                 resp_state, last_state, cyc);
      end else begin
        me = exp_q.pop_front();
        check("state",     DW'(resp_state),            DW'(me.state));
        check("rx_word",   link.phy_data_rx_phy2link,  me.data);
        check("ts1_seq",   DW'(ts1_seq),               DW'(me.seq));
        check("init_done", DW'(init_done),             DW'(me.init_done));
        check("LXRXPS",    DW'(link.LXRXPS),           DW'(me.lxrxps));
        check("FERR_N",    DW'(link.FERR_N),           DW'(1'b1));
        if (me.chk_prev) check("prev_word", last_data, me.prev);
        if (me.chk_cyc)  check("cycle", DW'(cyc), DW'(me.cyc));
      end
    end else if (resp_state == S_TS1) begin
      next_seq = last_seq + 4'd1;
      check("ts1_seq_step", DW'(ts1_seq), DW'(next_seq));
      check("ts1_word", link.phy_data_rx_phy2link, ts1_word(ts1_seq));
    end else begin
      check("steady_word", link.phy_data_rx_phy2link, (resp_state == S_TRET) ? TRET_W : '0);
    end
    if (exp_q.size() != 0 && exp_q[0].chk_cyc && cyc > exp_q[0].cyc) begin
      vectors++;
      miscompares++;
      $display("FAIL timeout: got state %0d required state %0d by cycle %0d",
               resp_state, exp_q[0].state, exp_q[0].cyc);
      void'(exp_q.pop_front());
    end
    started    = 1'b1;
    last_state = resp_state;
    last_seq   = ts1_seq;
    last_data  = link.phy_data_rx_phy2link;
  end

  // ---------------- stimulus ----------------
  logic [31:0] base;

  initial begin
    link.P_RST_N              = 1'b0;
    link.LXTXPS               = 1'b0;
    link.phy_bit_slip         = '0;
    link.phy_data_tx_link2phy = '0;
`ifdef HMC_RESP_TS1_CHECK_EN
    link.phy_data_tx_link2phy[15:0] = 16'hF035;
`endif
    // reset values
    push_exp(S_RESET, '0, 4'd0, 1'b0, 1'b0, 1'b0, '0, 1'b0, 32'd0);
    wait_cyc(3);
    res_n = 1'b1;
    wait_cyc(3);
    // LXTXPS alone must not leave RESET
    link.LXTXPS = 1'b1;
    wait_cyc(3);

    // normal init, no slips: 32 TS1 cycles (two full seq rounds)
    link.P_RST_N = 1'b1;
    base = cyc;
    push_pre_ts1(base);
    push_tail(base, 32'd32);
    drain(120);
    wait_cyc(5);

    // P_RST_N dropped in ACTIVE, then full replay
    link.P_RST_N = 1'b0;
    push_reset_next(cyc + 32'd1);
    wait_cyc(3);
    link.P_RST_N = 1'b1;
    base = cyc;
    push_pre_ts1(base);
    push_tail(base, 32'd32);
    drain(120);

    // slip storm: pulse every 10 TS1 cycles for 200 cycles; last pulse at
    // TS1 cycle 190, quiet reaches 32 at 222, next seq 15 is cycle 223
    link.P_RST_N = 1'b0;
    push_reset_next(cyc + 32'd1);
    wait_cyc(2);
    link.P_RST_N = 1'b1;
    base = cyc;
    push_pre_ts1(base);
    push_tail(base, 32'd224);
    wait_cyc(23);
    for (int i = 0; i < 200; i++) begin
      link.phy_bit_slip = (i % 10 == 0) ? 16'h0001 : 16'h0000;
      wait_cyc(1);
    end
    link.phy_bit_slip = '0;
    drain(120);

    // LXTXPS dropped during NULL_PRE
    link.LXTXPS = 1'b0;
    push_reset_next(cyc + 32'd1);
    wait_cyc(2);
    link.LXTXPS = 1'b1;
    base = cyc;
    push_exp(S_NULL_PRE, '0, 4'd0, 1'b0, 1'b1, 1'b1, '0, 1'b1, base + 32'd1);
    wait_cyc(5);
    link.LXTXPS = 1'b0;
    push_reset_next(cyc + 32'd1);
    wait_cyc(2);

    // asynchronous reset mid-TS1 (TS1 cycle 10), hold RESET, then replay
    link.LXTXPS = 1'b1;
    base = cyc;
    push_pre_ts1(base);
    wait_cyc(33);
    res_n = 1'b0;
    push_exp(S_RESET, '0, 4'd0, 1'b0, 1'b0, 1'b0, '0, 1'b1, cyc);
    link.P_RST_N = 1'b0;
    wait_cyc(2);
    res_n = 1'b1;
    wait_cyc(4);
    link.P_RST_N = 1'b1;
    base = cyc;
    push_pre_ts1(base);
    push_tail(base, 32'd32);
    drain(120);

`ifdef HMC_RESP_TS1_CHECK_EN
    // controller TX silent: TS1 must hold past the quiet window; TS1 seen
    // from TS1 cycle 40 on, run of 16 completes at 55, exit at seq 15 = 63
    link.P_RST_N = 1'b0;
    link.phy_data_tx_link2phy = '0;
    push_reset_next(cyc + 32'd1);
    wait_cyc(2);
    link.P_RST_N = 1'b1;
    base = cyc;
    push_pre_ts1(base);
    push_tail(base, 32'd64);
    wait_cyc(63);
    link.phy_data_tx_link2phy[15:0] = 16'hF031;
    drain(120);
`endif

    wait_cyc(5);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
